// File: rtl/memory_board.sv
// ---------------------------------------------------------------------------
// memory_board -- two-player "memory" (pairs) card game engine.
//
// Cards are stored as a ROWS x COLS grid of SYM_W-bit symbols, indexed
// y*COLS+x. Players alternate turns of two picks. A matching pair scores for
// the active player, who keeps the turn; a mismatched pair stays face-up for
// HIDE_S seconds and then the turn passes. A per-pick timer auto-picks the
// lowest free card after TIMEOUT_S seconds without a pick.
//
// Ports
//   clk            : sole clock, rising edge
//   rst            : asynchronous, active-low reset
//   btn_select     : one-cycle pick pulse for the card under (pos_x, pos_y)
//   pos_x, pos_y   : cursor position
//   sec_tick       : one-cycle pulse once per second
//   load_en        : symbol write strobe (accepted in FIRST or DONE only);
//                    an accepted write also starts a fresh game
//   load_addr      : card index to write
//   load_sym       : symbol value to write
//   revealed       : face-up flag per card
//   matched        : matched flag per card
//   card_sym       : symbol of the most recently flipped card
//   card_valid     : one-cycle pulse when a card is flipped
//   player         : active player (0/1)
//   score0, score1 : per-player pair count, saturating at ROWS*COLS/2
//   match_pulse    : one-cycle pulse on a matching pair
//   mismatch_pulse : one-cycle pulse on a mismatched pair
//   timeout_pulse  : one-cycle pulse when the timer forced a pick
//   game_over      : level, set when every card is matched
// ---------------------------------------------------------------------------
module memory_board #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SYM_W     = 3,
    parameter int TIMEOUT_S = 30,
    parameter int HIDE_S    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  btn_select,
    input  logic [$clog2(COLS)-1:0]               pos_x,
    input  logic [$clog2(ROWS)-1:0]               pos_y,
    input  logic                                  sec_tick,
    input  logic                                  load_en,
    input  logic [$clog2(ROWS*COLS)-1:0]          load_addr,
    input  logic [SYM_W-1:0]                      load_sym,
    output logic [ROWS*COLS-1:0]                  revealed,
    output logic [ROWS*COLS-1:0]                  matched,
    output logic [SYM_W-1:0]                      card_sym,
    output logic                                  card_valid,
    output logic                                  player,
    output logic [$clog2(ROWS*COLS/2+1)-1:0]      score0,
    output logic [$clog2(ROWS*COLS/2+1)-1:0]      score1,
    output logic                                  match_pulse,
    output logic                                  mismatch_pulse,
    output logic                                  timeout_pulse,
    output logic                                  game_over
);

    localparam int N       = ROWS * COLS;
    localparam int IDX_W   = $clog2(N);
    localparam int X_W     = $clog2(COLS);
    localparam int Y_W     = $clog2(ROWS);
    localparam int SC_W    = $clog2(N / 2 + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_S + 1);
    localparam int HIDE_W  = $clog2(HIDE_S + 1);

    typedef enum logic [2:0] {
        FIRST  = 3'd0,
        SECOND = 3'd1,
        CHECK  = 3'd2,
        HIDE   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t stateReg;
    state_t stateNext;

    // Symbol storage. The reset pattern must be applied to every entry, so
    // this is held in registers rather than a RAM macro.
    logic [SYM_W-1:0]   symMem [N];

    logic [IDX_W-1:0]   aReg;
    logic [IDX_W-1:0]   bReg;
    logic [SYM_W-1:0]   symAReg;
    logic [TIMER_W-1:0] turnTimerReg;
    logic [HIDE_W-1:0]  hideCntReg;

    // Control strobes from the FSM decode
    logic               flip;
    logic               autoPick;
    logic [IDX_W-1:0]   flipIdx;
    logic               setMatch;
    logic               mismatch;
    logic               hideDone;

    logic               inTurn;
    logic               posInRange;
    logic               addrInRange;
    logic [IDX_W-1:0]   pickIdx;
    logic               btnValid;
    logic               timeoutHit;
    logic               loadAcc;
    logic               freeFound;
    logic [IDX_W-1:0]   freeIdx;
    logic               allMatchAfter;

    logic [N-1:0]       pairMask;
    logic [N-1:0]       revealedNext;
    logic [N-1:0]       matchedNext;

    // ------------------------------------------------------------------
    // Pick qualification
    // ------------------------------------------------------------------
    // Compare one bit wider than the cursor so non-power-of-2 boards can
    // flag positions past the last row/column.
    assign posInRange  = ({1'b0, pos_x} < (X_W + 1)'(COLS)) &&
                         ({1'b0, pos_y} < (Y_W + 1)'(ROWS));
    assign addrInRange = ({1'b0, load_addr} < (IDX_W + 1)'(N));
    assign pickIdx     = IDX_W'(int'(pos_y) * COLS + int'(pos_x));

    assign inTurn   = (stateReg == FIRST) || (stateReg == SECOND);
    assign btnValid = btn_select && posInRange &&
                      !revealed[pickIdx] && !matched[pickIdx];
    // The timer "reaches" TIMEOUT_S on the tick that would take it there;
    // the forced pick happens on that same edge.
    assign timeoutHit = inTurn && sec_tick &&
                        (turnTimerReg == TIMER_W'(TIMEOUT_S - 1));
    assign loadAcc  = load_en && ((stateReg == FIRST) || (stateReg == DONE));

    // Lowest-index card that is neither face-up nor matched.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!revealed[i] && !matched[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-card flag update
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_card
            assign pairMask[gi] = (aReg == IDX_W'(gi)) || (bReg == IDX_W'(gi));

            assign revealedNext[gi] =
                loadAcc                                     ? 1'b0 :
                (flip && (flipIdx == IDX_W'(gi)))           ? 1'b1 :
                ((setMatch || hideDone) && pairMask[gi])    ? 1'b0 :
                                                              revealed[gi];

            assign matchedNext[gi] =
                loadAcc                     ? 1'b0 :
                (setMatch && pairMask[gi])  ? 1'b1 :
                                              matched[gi];
        end
    endgenerate

    // Decided from the current flags and the A/B pair only, so the game-over
    // decision does not loop through the FSM decode.
    assign allMatchAfter = &(matched | pairMask);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= FIRST;
        end else begin
            stateReg <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = stateReg;
        flip      = 1'b0;
        autoPick  = 1'b0;
        flipIdx   = '0;
        setMatch  = 1'b0;
        mismatch  = 1'b0;
        hideDone  = 1'b0;

        if (loadAcc) begin
            stateNext = FIRST;
        end else begin
            case (stateReg)
                FIRST, SECOND: begin
                    // A valid button press pre-empts a coinciding timeout.
                    // An invalid press does not, so the timer cannot stall.
                    if (btnValid) begin
                        flip    = 1'b1;
                        flipIdx = pickIdx;
                    end else if (timeoutHit && freeFound) begin
                        flip     = 1'b1;
                        autoPick = 1'b1;
                        flipIdx  = freeIdx;
                    end
                    if (flip) begin
                        stateNext = (stateReg == FIRST) ? SECOND : CHECK;
                    end
                end
                CHECK: begin
                    // card_sym still holds card B's symbol here.
                    if (card_sym == symAReg) begin
                        setMatch  = 1'b1;
                        stateNext = allMatchAfter ? DONE : FIRST;
                    end else begin
                        mismatch  = 1'b1;
                        stateNext = HIDE;
                    end
                end
                HIDE: begin
                    if (sec_tick && (hideCntReg == HIDE_W'(HIDE_S - 1))) begin
                        hideDone  = 1'b1;
                        stateNext = FIRST;
                    end
                end
                DONE: begin
                    stateNext = DONE;
                end
                default: begin
                    stateNext = FIRST;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                symMem[i] <= SYM_W'(i / 2);
            end
            revealed       <= '0;
            matched        <= '0;
            card_sym       <= '0;
            card_valid     <= 1'b0;
            player         <= 1'b0;
            score0         <= '0;
            score1         <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            timeout_pulse  <= 1'b0;
            game_over      <= 1'b0;
            aReg           <= '0;
            bReg           <= '0;
            symAReg        <= '0;
            turnTimerReg   <= '0;
            hideCntReg     <= '0;
        end else begin
            revealed       <= revealedNext;
            matched        <= matchedNext;
            card_valid     <= flip;
            match_pulse    <= setMatch;
            mismatch_pulse <= mismatch;
            timeout_pulse  <= autoPick;

            if (flip) begin
                card_sym <= symMem[flipIdx];
                if (stateReg == FIRST) begin
                    aReg    <= flipIdx;
                    symAReg <= symMem[flipIdx];
                end else begin
                    bReg <= flipIdx;
                end
            end

            if (loadAcc && addrInRange) begin
                symMem[load_addr] <= load_sym;
            end

            // Turn timer: runs only while waiting for a pick.
            if (loadAcc || flip || timeoutHit || !inTurn) begin
                turnTimerReg <= '0;
            end else if (sec_tick) begin
                turnTimerReg <= turnTimerReg + TIMER_W'(1);
            end

            if ((stateReg != HIDE) || hideDone) begin
                hideCntReg <= '0;
            end else if (sec_tick) begin
                hideCntReg <= hideCntReg + HIDE_W'(1);
            end

            if (loadAcc) begin
                score0 <= '0;
                score1 <= '0;
            end else if (setMatch) begin
                if (!player && (score0 != SC_W'(N / 2))) begin
                    score0 <= score0 + SC_W'(1);
                end
                if (player && (score1 != SC_W'(N / 2))) begin
                    score1 <= score1 + SC_W'(1);
                end
            end

            if (loadAcc) begin
                player <= 1'b0;
            end else if (hideDone) begin
                player <= ~player;
            end

            if (loadAcc) begin
                game_over <= 1'b0;
            end else if (setMatch && allMatchAfter) begin
                game_over <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_board.sv
// ---------------------------------------------------------------------------
// tb_memory_board -- self-checking bench for memory_board (default params).
// Directed game scenarios followed by randomized play, all compared every
// cycle against a turn-level reference model of the game rules.
// ---------------------------------------------------------------------------
module tb_memory_board;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;
    localparam int TO_S = 30;
    localparam int HD_S = 2;

    // Model phases of a turn
    localparam int P_FIRST  = 0;
    localparam int P_SECOND = 1;
    localparam int P_CHECK  = 2;
    localparam int P_HIDE   = 3;
    localparam int P_DONE   = 4;

    logic        clk;
    logic        rst;
    logic        btn_select;
    logic [1:0]  pos_x;
    logic [1:0]  pos_y;
    logic        sec_tick;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [2:0]  load_sym;
    logic [15:0] revealed;
    logic [15:0] matched;
    logic [2:0]  card_sym;
    logic        card_valid;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        match_pulse;
    logic        mismatch_pulse;
    logic        timeout_pulse;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mSym [N];
    logic [15:0] mRev;
    logic [15:0] mMat;
    int          mCs;
    logic        mCv, mMp, mMm, mTo, mGo, mPl;
    int          mS0, mS1;
    int          mPhase;
    int          mTimer;
    int          mHide;
    int          mA, mB;

    memory_board dut (
        .clk            (clk),
        .rst            (rst),
        .btn_select     (btn_select),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .sec_tick       (sec_tick),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_sym       (load_sym),
        .revealed       (revealed),
        .matched        (matched),
        .card_sym       (card_sym),
        .card_valid     (card_valid),
        .player         (player),
        .score0         (score0),
        .score1         (score1),
        .match_pulse    (match_pulse),
        .mismatch_pulse (mismatch_pulse),
        .timeout_pulse  (timeout_pulse),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < N; i++) mSym[i] = (i / 2) % 8;
        mRev = '0; mMat = '0; mCs = 0;
        mCv = 0; mMp = 0; mMm = 0; mTo = 0; mGo = 0; mPl = 0;
        mS0 = 0; mS1 = 0; mPhase = P_FIRST; mTimer = 0; mHide = 0;
        mA = 0; mB = 0;
    endfunction

    // One clock edge of the game rules, given the inputs sampled at it.
    function automatic void modelStep(input bit b, input int x, input int y, input bit t,
                                      input bit ld, input int la, input int ls);
        int pick;
        int idx;
        mCv = 0; mMp = 0; mMm = 0; mTo = 0;
        if (ld && (mPhase == P_FIRST || mPhase == P_DONE)) begin
            mSym[la] = ls;
            mRev = '0; mMat = '0; mS0 = 0; mS1 = 0; mPl = 0;
            mTimer = 0; mGo = 0; mPhase = P_FIRST;
        end else if (mPhase == P_FIRST || mPhase == P_SECOND) begin
            pick = -1;
            idx  = y * COLS + x;
            if (b && x < COLS && y < ROWS && !mRev[idx] && !mMat[idx]) begin
                pick = idx;
            end else if (t && mTimer + 1 == TO_S) begin
                for (int i = N - 1; i >= 0; i--) if (!mRev[i] && !mMat[i]) pick = i;
                mTo = (pick >= 0);
            end
            if (pick >= 0) begin
                mRev[pick] = 1'b1;
                mCs = mSym[pick];
                mCv = 1;
                mTimer = 0;
                if (mPhase == P_FIRST) begin mA = pick; mPhase = P_SECOND; end
                else begin mB = pick; mPhase = P_CHECK; end
            end else if (t) begin
                mTimer++;
            end
        end else if (mPhase == P_CHECK) begin
            if (mSym[mA] == mSym[mB]) begin
                mMat[mA] = 1'b1; mMat[mB] = 1'b1;
                mRev[mA] = 1'b0; mRev[mB] = 1'b0;
                if (mPl == 0) mS0 = (mS0 < N / 2) ? mS0 + 1 : mS0;
                else          mS1 = (mS1 < N / 2) ? mS1 + 1 : mS1;
                mMp = 1;
                if (&mMat) begin mGo = 1; mPhase = P_DONE; end
                else mPhase = P_FIRST;
            end else begin
                mMm = 1; mHide = 0; mPhase = P_HIDE;
            end
        end else if (mPhase == P_HIDE) begin
            if (t) begin
                mHide++;
                if (mHide == HD_S) begin
                    mRev[mA] = 1'b0; mRev[mB] = 1'b0;
                    mPl = ~mPl;
                    mPhase = P_FIRST;
                end
            end
        end
    endfunction

    task automatic compareAll();
        chk("revealed",       32'(revealed),       32'(mRev));
        chk("matched",        32'(matched),        32'(mMat));
        chk("card_sym",       32'(card_sym),       32'(mCs));
        chk("card_valid",     32'(card_valid),     32'(mCv));
        chk("player",         32'(player),         32'(mPl));
        chk("score0",         32'(score0),         32'(mS0));
        chk("score1",         32'(score1),         32'(mS1));
        chk("match_pulse",    32'(match_pulse),    32'(mMp));
        chk("mismatch_pulse", 32'(mismatch_pulse), 32'(mMm));
        chk("timeout_pulse",  32'(timeout_pulse),  32'(mTo));
        chk("game_over",      32'(game_over),      32'(mGo));
    endtask

    task automatic step(input bit b, input int x, input int y, input bit t,
                        input bit ld, input int la, input int ls);
        @(negedge clk);
        btn_select = b;
        pos_x      = 2'(x);
        pos_y      = 2'(y);
        sec_tick   = t;
        load_en    = ld;
        load_addr  = 4'(la);
        load_sym   = 3'(ls);
        @(posedge clk);
        modelStep(b, x, y, t, ld, la, ls);
        #1;
        compareAll();
    endtask

    task automatic pick(input int i);
        step(1'b1, i % COLS, i / COLS, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic tick();
        step(1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        btn_select = 1'b0; sec_tick = 1'b0; load_en = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int btnP;
        int tickP;
        rst = 1'b1;
        btn_select = 1'b0; pos_x = '0; pos_y = '0; sec_tick = 1'b0;
        load_en = 1'b0; load_addr = '0; load_sym = '0;
        modelReset();
        #2;
        doReset();

        // Matching pair (0,0) and (1,0)
        pick(0);
        chk("d35_sym_a", 32'(card_sym), 32'd0);
        chk("d35_valid_a", 32'(card_valid), 32'd1);
        pick(1);
        chk("d35_sym_b", 32'(card_sym), 32'd0);
        idle();
        chk("d35_match", 32'(match_pulse), 32'd1);
        chk("d35_matched", 32'(matched[1:0]), 32'h3);
        chk("d35_score0", 32'(score0), 32'd1);
        chk("d35_player", 32'(player), 32'd0);

        // Mismatch (0,0)/(2,0): visible for two ticks, then turn passes
        doReset();
        pick(0);
        pick(2);
        idle();
        chk("d36_mismatch", 32'(mismatch_pulse), 32'd1);
        chk("d36_rev_hold", 32'(revealed), 32'h5);
        tick();
        chk("d36_rev_tick1", 32'(revealed), 32'h5);
        tick();
        chk("d36_rev_clear", 32'(revealed), 32'h0);
        chk("d36_player", 32'(player), 32'd1);

        // Timeout auto-pick, then timer restarts
        doReset();
        for (int i = 0; i < TO_S - 1; i++) tick();
        chk("d37_no_early_to", 32'(timeout_pulse), 32'd0);
        tick();
        chk("d37_timeout", 32'(timeout_pulse), 32'd1);
        chk("d37_card0", 32'(revealed), 32'h1);
        for (int i = 0; i < TO_S - 1; i++) tick();
        chk("d37_restart", 32'(revealed), 32'h1);
        tick();
        chk("d37_second_to", 32'(revealed), 32'h3);
        idle();

        // Button coincides with timeout: button wins
        doReset();
        for (int i = 0; i < TO_S - 1; i++) tick();
        step(1'b1, 3, 3, 1'b1, 1'b0, 0, 0);
        chk("d38_card15", 32'(revealed), 32'h8000);
        chk("d38_no_to", 32'(timeout_pulse), 32'd0);
        chk("d38_sym", 32'(card_sym), 32'd7);

        // Re-pick of card A ignored; load ignored in SECOND
        doReset();
        pick(0);
        pick(0);
        chk("d39_no_valid", 32'(card_valid), 32'd0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1, 5);
        pick(1);
        chk("d39_valid_b", 32'(card_valid), 32'd1);
        idle();
        chk("d39_match", 32'(match_pulse), 32'd1);

        // Reset in HIDE aborts the turn
        doReset();
        pick(0);
        pick(1);
        idle();
        pick(2);
        pick(4);
        idle();
        tick();
        doReset();
        chk("d34_score0", 32'(score0), 32'd0);
        chk("d34_revealed", 32'(revealed), 32'd0);

        // Full game
        doReset();
        for (int k = 0; k < N / 2; k++) begin
            pick(2 * k);
            pick(2 * k + 1);
            idle();
        end
        chk("d40_game_over", 32'(game_over), 32'd1);
        chk("d40_score0", 32'(score0), 32'd8);
        pick(0);
        chk("d40_ignored", 32'(card_valid), 32'd0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 0, 0);
        chk("d40_go_clear", 32'(game_over), 32'd0);
        chk("d40_score_clr", 32'(score0), 32'd0);
        pick(0);
        chk("d40_replay", 32'(card_valid), 32'd1);

        // Randomized play
        doReset();
        for (int seg = 0; seg < 6; seg++) begin
            btnP  = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 20 : 60);
            tickP = (seg < 3) ? 40 : 80;
            for (int c = 0; c < 500; c++) begin
                step($urandom_range(0, 99) < btnP,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < tickP,
                     $urandom_range(0, 99) < 3,
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
